mod_updown_counter: RTL and testbench

Parametrised synchronous up/down modulo counter for the clock/calendar datapath: seconds, minutes, hours, days and months, with a runtime-adjustable upper limit for days-in-month. Counts on single-cycle tick strobes and supports load, wrap or saturate modes, and registered carry/borrow pulses for cascading. It replaces the ad-hoc edge-triggered counters with one clocked block that every time/date field instantiates.

---
 rtl/clock_pkg.sv | 64 ++++++
 rtl/bin2bcd_2d.sv | 37 +++
 rtl/mod_updown_counter.sv | 195 +++++++++++++++++++
 tb/tb_mod_updown_counter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : clock_pkg (package)
//  Purpose  : Shared definitions for the clock/calendar datapath: field
//             bounds, the days-in-month table used to drive a day counter's
//             runtime limit, the counter update-action encoding and a
//             constant binary-to-BCD helper.
//  Contents : SEC_MAX, MIN_MAX, HOUR_MAX, DAY_MIN, DAY_MAX, MON_MIN, MON_MAX
//             DAYS_IN_MONTH table, days_in_month(), bcd_of(), upd_e
//  Revision : 1.0  initial release
// ============================================================================
package clock_pkg;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;
  localparam int DAY_MIN  = 1;
  localparam int DAY_MAX  = 31;
  localparam int MON_MIN  = 1;
  localparam int MON_MAX  = 12;

  // Index 0 is January. February holds the non-leap value; the leap-year
  // adjustment is applied in days_in_month().
  localparam logic [4:0] DAYS_IN_MONTH [12] = '{
    5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
    5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
  };

  // What the counter does on the coming edge, in priority order of the
  // decision logic.
  typedef enum logic [2:0] {
    ACT_HOLD    = 3'd0,
    ACT_CLAMP   = 3'd1,
    ACT_LOAD    = 3'd2,
    ACT_INC     = 3'd3,
    ACT_DEC     = 3'd4,
    ACT_WRAP_UP = 3'd5,
    ACT_WRAP_DN = 3'd6
  } upd_e;

  // Day-counter limit for a month (1..12). Out-of-range months fall back to
  // 31 so a mis-set month field never shrinks the day range below legal.
  function automatic logic [4:0] days_in_month(input logic [3:0] month,
                                               input logic       leap);
    int idx;
    idx = int'(month) - 1;
    if (month == 4'd2 && leap) begin
      return 5'd29;
    end
    if (idx >= 0 && idx < 12) begin
      return DAYS_IN_MONTH[idx];
    end
    return 5'd31;
  endfunction

  // Two-digit BCD of a constant, used for the BCD register reset value.
  function automatic logic [7:0] bcd_of(input int value);
    int v;
    v = value % 100;
    return {4'(v / 10), 4'(v % 10)};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_2d.sv
`default_nettype none
// ============================================================================
//  Module   : bin2bcd_2d
//  Purpose  : Combinational binary to two-digit BCD conversion using the
//             shift-and-add-3 (double-dabble) algorithm. Inputs above 99
//             produce undefined digits; callers bound their range to 0..99.
//  Ports    : bin  [6:0] in  - binary value 0..99
//             tens [3:0] out - BCD tens digit
//             ones [3:0] out - BCD ones digit
//  Revision : 1.0  initial release
// ============================================================================
module bin2bcd_2d (
  input  logic [6:0] bin,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  // [14:11] tens, [10:7] ones, [6:0] binary being shifted in.
  logic [14:0] sr;

  always_comb begin
    sr = {8'd0, bin};
    for (int i = 0; i < 7; i++) begin
      if (sr[10:7] >= 4'd5) begin
        sr[10:7] = sr[10:7] + 4'd3;
      end
      if (sr[14:11] >= 4'd5) begin
        sr[14:11] = sr[14:11] + 4'd3;
      end
      sr = sr << 1;
    end
    tens = sr[14:11];
    ones = sr[10:7];
  end

endmodule
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mod_updown_counter
//  Purpose  : Parametrised up/down modulo counter for the time/date fields.
//             Counts once per cycle on tick strobes, supports synchronous
//             load with clipping, wrap or saturate at the bounds, a runtime
//             upper limit, and registered carry/borrow pulses for cascading.
//  Options  : MOD_UPDOWN_COUNTER_BCD_EN - adds registered bcd_tens/bcd_ones
//             outputs (requires MAX_VAL <= 99).
//  Ports    : clk       in         rising-edge clock
//             rst       in         asynchronous active-high reset
//             en        in         enable for ticks and load
//             tick_up   in         increment strobe
//             tick_down in         decrement strobe
//             load      in         synchronous load of load_val
//             load_val  in  WIDTH  value to load (clipped)
//             limit     in  WIDTH  runtime upper bound
//             count     out WIDTH  current value
//             carry     out        one-cycle pulse on up-wrap
//             borrow    out        one-cycle pulse on down-wrap
//             at_max    out        count == effective max
//             at_min    out        count == MIN_VAL
//             bcd_tens  out 4      (option) BCD tens of count
//             bcd_ones  out 4      (option) BCD ones of count
//  Revision : 1.0  initial release
// ============================================================================
module mod_updown_counter
  import clock_pkg::*;
#(
  parameter int WIDTH    = 6,
  parameter int MIN_VAL  = 0,
  parameter int MAX_VAL  = 59,
  parameter int RST_VAL  = 0,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick_up,
  input  logic             tick_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             at_max,
  output logic             at_min
`ifdef MOD_UPDOWN_COUNTER_BCD_EN
  ,
  output logic [3:0]       bcd_tens,
  output logic [3:0]       bcd_ones
`endif
);

  // One extra bit keeps every comparison and +/-1 free of wrap-around at
  // 2^WIDTH-1 and below zero.
  localparam int EW = WIDTH + 1;
  localparam logic [EW-1:0] MIN_X = EW'(MIN_VAL);
  localparam logic [EW-1:0] MAX_X = EW'(MAX_VAL);
  localparam logic [EW-1:0] RST_X = EW'(RST_VAL);

  if (WIDTH < 1 || WIDTH > 16) begin : g_err_width
    $error("mod_updown_counter: WIDTH must be 1..16");
  end
  if (MIN_VAL < 0 || MIN_VAL > MAX_VAL || MAX_VAL >= (1 << WIDTH)) begin : g_err_bounds
    $error("mod_updown_counter: need 0 <= MIN_VAL <= MAX_VAL < 2**WIDTH");
  end
  if (RST_VAL < MIN_VAL || RST_VAL > MAX_VAL) begin : g_err_rst
    $error("mod_updown_counter: RST_VAL outside MIN_VAL..MAX_VAL");
  end

  logic [EW-1:0] cnt_x;
  logic [EW-1:0] lim_x;
  logic [EW-1:0] load_x;
  logic [EW-1:0] eff_max;
  logic [EW-1:0] load_clip;
  logic [EW-1:0] count_nx;
  logic          carry_nx;
  logic          borrow_nx;
  upd_e          act;

  assign cnt_x  = {1'b0, count};
  assign lim_x  = {1'b0, limit};
  assign load_x = {1'b0, load_val};

  // eff_max = min(limit, MAX_VAL), never below MIN_VAL.
  always_comb begin
    eff_max = lim_x;
    if (lim_x > MAX_X) begin
      eff_max = MAX_X;
    end
    if (eff_max < MIN_X) begin
      eff_max = MIN_X;
    end
  end

  always_comb begin
    load_clip = load_x;
    if (load_x < MIN_X) begin
      load_clip = MIN_X;
    end else if (load_x > eff_max) begin
      load_clip = eff_max;
    end
  end

  // Decide the action. An out-of-range count (limit just dropped) is pulled
  // back regardless of enable and overrides any load or tick that cycle.
  always_comb begin
    act = ACT_HOLD;
    if (cnt_x > eff_max) begin
      act = ACT_CLAMP;
    end else if (en && load) begin
      act = ACT_LOAD;
    end else if (en && tick_up && !tick_down) begin
      if (cnt_x == eff_max) begin
        act = (SATURATE != 0) ? ACT_HOLD : ACT_WRAP_UP;
      end else begin
        act = ACT_INC;
      end
    end else if (en && tick_down && !tick_up) begin
      if (cnt_x == MIN_X) begin
        act = (SATURATE != 0) ? ACT_HOLD : ACT_WRAP_DN;
      end else begin
        act = ACT_DEC;
      end
    end
  end

  always_comb begin
    count_nx  = cnt_x;
    carry_nx  = 1'b0;
    borrow_nx = 1'b0;
    case (act)
      ACT_CLAMP:   count_nx = eff_max;
      ACT_LOAD:    count_nx = load_clip;
      ACT_INC:     count_nx = cnt_x + EW'(1);
      ACT_DEC:     count_nx = cnt_x - EW'(1);
      ACT_WRAP_UP: begin
        count_nx = MIN_X;
        carry_nx = 1'b1;
      end
      ACT_WRAP_DN: begin
        count_nx  = eff_max;
        borrow_nx = 1'b1;
      end
      default:     count_nx = cnt_x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= RST_X[WIDTH-1:0];
      carry  <= 1'b0;
      borrow <= 1'b0;
    end else begin
      count  <= count_nx[WIDTH-1:0];
      carry  <= carry_nx;
      borrow <= borrow_nx;
    end
  end

  assign at_max = (cnt_x == eff_max);
  assign at_min = (cnt_x == MIN_X);

`ifdef MOD_UPDOWN_COUNTER_BCD_EN
  localparam logic [7:0] RST_BCD = bcd_of(RST_VAL);

  if (MAX_VAL > 99) begin : g_err_bcd_range
    $error("mod_updown_counter: BCD outputs require MAX_VAL <= 99");
  end

  logic [3:0] tens_nx;
  logic [3:0] ones_nx;

  // Convert the next count so the digits land on the same edge as count.
  bin2bcd_2d u_bin2bcd (
    .bin  (7'(count_nx)),
    .tens (tens_nx),
    .ones (ones_nx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd_tens <= RST_BCD[7:4];
      bcd_ones <= RST_BCD[3:0];
    end else begin
      bcd_tens <= tens_nx;
      bcd_ones <= ones_nx;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mod_updown_counter
//  Purpose  : Self-checking bench for mod_updown_counter. Three instances
//             (seconds-style wrap 0..59, month-style saturate 1..12,
//             day-style wrap 1..31) share control strobes; each has its own
//             limit and load value and is tracked by a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mod_updown_counter;

  localparam int W  [3] = '{6, 4, 5};
  localparam int MN [3] = '{0, 1, 1};
  localparam int MX [3] = '{59, 12, 31};
  localparam int RV [3] = '{0, 1, 1};
  localparam int SA [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       up  = 1'b0;
  logic       dn  = 1'b0;
  logic       ld  = 1'b0;
  logic [5:0] lim [3];
  logic [5:0] lv  [3];
  logic [5:0] c0;
  logic [3:0] c1;
  logic [4:0] c2;
  logic       cy  [3];
  logic       bw  [3];
  logic       amx [3];
  logic       amn [3];
`ifdef MOD_UPDOWN_COUNTER_BCD_EN
  logic [3:0] bt [3];
  logic [3:0] bo [3];
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(6), .MIN_VAL(0), .MAX_VAL(59), .RST_VAL(0), .SATURATE(0)) u_sec (
    .clk(clk), .rst(rst), .en(en), .tick_up(up), .tick_down(dn), .load(ld),
    .load_val(lv[0]), .limit(lim[0]), .count(c0), .carry(cy[0]), .borrow(bw[0]),
    .at_max(amx[0]), .at_min(amn[0])
`ifdef MOD_UPDOWN_COUNTER_BCD_EN
    , .bcd_tens(bt[0]), .bcd_ones(bo[0])
`endif
  );

  mod_updown_counter #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .RST_VAL(1), .SATURATE(1)) u_mon (
    .clk(clk), .rst(rst), .en(en), .tick_up(up), .tick_down(dn), .load(ld),
    .load_val(lv[1][3:0]), .limit(lim[1][3:0]), .count(c1), .carry(cy[1]), .borrow(bw[1]),
    .at_max(amx[1]), .at_min(amn[1])
`ifdef MOD_UPDOWN_COUNTER_BCD_EN
    , .bcd_tens(bt[1]), .bcd_ones(bo[1])
`endif
  );

  mod_updown_counter #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .RST_VAL(1), .SATURATE(0)) u_day (
    .clk(clk), .rst(rst), .en(en), .tick_up(up), .tick_down(dn), .load(ld),
    .load_val(lv[2][4:0]), .limit(lim[2][4:0]), .count(c2), .carry(cy[2]), .borrow(bw[2]),
    .at_max(amx[2]), .at_min(amn[2])
`ifdef MOD_UPDOWN_COUNTER_BCD_EN
    , .bcd_tens(bt[2]), .bcd_ones(bo[2])
`endif
  );

  // ---------------- behavioural reference ----------------
  int m_cnt [3];
  bit m_cy  [3];
  bit m_bw  [3];

  function automatic int emax(int i);
    int l;
    l = int'(lim[i]) & ((1 << W[i]) - 1);
    if (l > MX[i]) l = MX[i];
    if (l < MN[i]) l = MN[i];
    return l;
  endfunction

  function automatic int cnt_of(int i);
    case (i)
      0:       return int'(c0);
      1:       return int'(c1);
      default: return int'(c2);
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_cnt[i] <= RV[i];
        m_cy[i]  <= 1'b0;
        m_bw[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        int em, v, nc;
        bit ncy, nbw;
        em  = emax(i);
        v   = int'(lv[i]) & ((1 << W[i]) - 1);
        nc  = m_cnt[i];
        ncy = 1'b0;
        nbw = 1'b0;
        if (m_cnt[i] > em) begin
          nc = em;
        end else if (en && ld) begin
          nc = (v < MN[i]) ? MN[i] : ((v > em) ? em : v);
        end else if (en && up && !dn) begin
          if (m_cnt[i] < em) nc = m_cnt[i] + 1;
          else if (SA[i] == 0) begin nc = MN[i]; ncy = 1'b1; end
        end else if (en && dn && !up) begin
          if (m_cnt[i] > MN[i]) nc = m_cnt[i] - 1;
          else if (SA[i] == 0) begin nc = em; nbw = 1'b1; end
        end
        m_cnt[i] <= nc;
        m_cy[i]  <= ncy;
        m_bw[i]  <= nbw;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic default_limits();
    lim[0] = 6'd59;
    lim[1] = 6'd12;
    lim[2] = 6'd31;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (c0 !== 6'd0) begin bad++; $display("FAIL reset_c0 got=%0d exp=0", c0); end
    total++; if (c1 !== 4'd1) begin bad++; $display("FAIL reset_c1 got=%0d exp=1", c1); end
    total++; if (c2 !== 5'd1) begin bad++; $display("FAIL reset_c2 got=%0d exp=1", c2); end
    total++; if (cy[0] !== 1'b0 || bw[0] !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", cy[0], bw[0]); end
    total++; if (amn[0] !== 1'b1 || amx[0] !== 1'b0) begin bad++; $display("FAIL reset_flags got min=%b max=%b exp min=1 max=0", amn[0], amx[0]); end
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_wrap();
    int cc0, cc1, cc2;
    cc0 = 0; cc1 = 0; cc2 = 0;
    en = 1'b1;
    up = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      cyc();
      if (cy[0]) cc0++;
      if (cy[1]) cc1++;
      if (cy[2]) cc2++;
      if (k == 59) begin
        total++; if (c0 !== 6'd59 || amx[0] !== 1'b1 || cy[0] !== 1'b0) begin
          bad++; $display("FAIL wrap_pre got cnt=%0d max=%b cy=%b exp cnt=59 max=1 cy=0", c0, amx[0], cy[0]);
        end
      end
    end
    total++; if (c0 !== 6'd0 || cy[0] !== 1'b1 || amn[0] !== 1'b1) begin
      bad++; $display("FAIL wrap_edge got cnt=%0d cy=%b min=%b exp cnt=0 cy=1 min=1", c0, cy[0], amn[0]);
    end
    total++; if (cc0 !== 1) begin bad++; $display("FAIL wrap_carry_count got=%0d exp=1", cc0); end
    total++; if (c1 !== 4'd12 || cc1 !== 0) begin bad++; $display("FAIL wrap_sat got cnt=%0d carries=%0d exp cnt=12 carries=0", c1, cc1); end
    total++; if (c2 !== 5'd30 || cc2 !== 1) begin bad++; $display("FAIL wrap_day got cnt=%0d carries=%0d exp cnt=30 carries=1", c2, cc2); end
    up = 1'b0;
    cyc();
    total++; if (cy[0] !== 1'b0 || c0 !== 6'd0) begin bad++; $display("FAIL wrap_post got cy=%b cnt=%0d exp cy=0 cnt=0", cy[0], c0); end
  endtask

  task automatic test_down();
    dn = 1'b1;
    cyc();
    total++; if (c0 !== 6'd59 || bw[0] !== 1'b1 || cy[0] !== 1'b0) begin
      bad++; $display("FAIL down_wrap got cnt=%0d bw=%b cy=%b exp cnt=59 bw=1 cy=0", c0, bw[0], cy[0]);
    end
    total++; if (c1 !== 4'd11 || bw[1] !== 1'b0 || c2 !== 5'd29) begin
      bad++; $display("FAIL down_others got c1=%0d bw1=%b c2=%0d exp c1=11 bw1=0 c2=29", c1, bw[1], c2);
    end
    dn = 1'b0;
    cyc();
    total++; if (bw[0] !== 1'b0 || c0 !== 6'd59) begin bad++; $display("FAIL down_post got bw=%b cnt=%0d exp bw=0 cnt=59", bw[0], c0); end
    ld = 1'b1; lv[0] = 6'd30;
    cyc();
    ld = 1'b0; up = 1'b1; dn = 1'b1;
    cyc();
    total++; if (c0 !== 6'd30 || cy[0] !== 1'b0 || bw[0] !== 1'b0) begin
      bad++; $display("FAIL up_and_down got cnt=%0d cy=%b bw=%b exp cnt=30 cy=0 bw=0", c0, cy[0], bw[0]);
    end
    up = 1'b0; dn = 1'b0;
  endtask

  task automatic test_saturate();
    ld = 1'b1; lv[1] = 6'd12;
    cyc();
    ld = 1'b0; up = 1'b1;
    cyc();
    total++; if (c1 !== 4'd12 || cy[1] !== 1'b0 || amx[1] !== 1'b1) begin
      bad++; $display("FAIL sat_top got cnt=%0d cy=%b max=%b exp cnt=12 cy=0 max=1", c1, cy[1], amx[1]);
    end
    up = 1'b0; ld = 1'b1; lv[1] = 6'd1;
    cyc();
    ld = 1'b0; dn = 1'b1;
    cyc();
    total++; if (c1 !== 4'd1 || bw[1] !== 1'b0 || amn[1] !== 1'b1) begin
      bad++; $display("FAIL sat_bottom got cnt=%0d bw=%b min=%b exp cnt=1 bw=0 min=1", c1, bw[1], amn[1]);
    end
    dn = 1'b0;
  endtask

  task automatic test_limit();
    ld = 1'b1; lv[2] = 6'd31;
    cyc();
    ld = 1'b0;
    total++; if (c2 !== 5'd31 || amx[2] !== 1'b1) begin bad++; $display("FAIL limit_load got cnt=%0d max=%b exp cnt=31 max=1", c2, amx[2]); end
    lim[2] = 6'd28; up = 1'b1;
    #1;
    total++; if (amx[2] !== 1'b0) begin bad++; $display("FAIL limit_flag_follow got max=%b exp=0", amx[2]); end
    cyc();
    total++; if (c2 !== 5'd28 || cy[2] !== 1'b0 || amx[2] !== 1'b1) begin
      bad++; $display("FAIL limit_clamp got cnt=%0d cy=%b max=%b exp cnt=28 cy=0 max=1", c2, cy[2], amx[2]);
    end
    cyc();
    total++; if (c2 !== 5'd1 || cy[2] !== 1'b1) begin bad++; $display("FAIL limit_wrap got cnt=%0d cy=%b exp cnt=1 cy=1", c2, cy[2]); end
    up = 1'b0;
    default_limits();
    ld = 1'b1; lv[0] = 6'd40;
    cyc();
    ld = 1'b0; en = 1'b0; lim[0] = 6'd20; up = 1'b1;
    cyc();
    total++; if (c0 !== 6'd20 || cy[0] !== 1'b0) begin bad++; $display("FAIL clamp_disabled got cnt=%0d cy=%b exp cnt=20 cy=0", c0, cy[0]); end
    en = 1'b1; up = 1'b0;
    default_limits();
  endtask

  task automatic test_load_clip();
    lim[0] = 6'd30; lv[0] = 6'd45; lv[2] = 6'd0; ld = 1'b1;
    cyc();
    total++; if (c0 !== 6'd30) begin bad++; $display("FAIL load_clip_hi got=%0d exp=30", c0); end
    total++; if (c2 !== 5'd1) begin bad++; $display("FAIL load_clip_lo got=%0d exp=1", c2); end
    lv[0] = 6'd10; up = 1'b1;
    cyc();
    total++; if (c0 !== 6'd10 || cy[0] !== 1'b0) begin bad++; $display("FAIL load_wins got cnt=%0d cy=%b exp cnt=10 cy=0", c0, cy[0]); end
    up = 1'b0;
    default_limits();
`ifdef MOD_UPDOWN_COUNTER_BCD_EN
    lv[0] = 6'd47;
    cyc();
    total++; if (c0 !== 6'd47 || bt[0] !== 4'd4 || bo[0] !== 4'd7) begin
      bad++; $display("FAIL bcd_47 got cnt=%0d tens=%0d ones=%0d exp 47 4 7", c0, bt[0], bo[0]);
    end
`endif
    ld = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      en = ($urandom_range(0, 7) != 0);
      up = 1'($urandom_range(0, 1));
      dn = ($urandom_range(0, 3) == 0);
      ld = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < 3; i++) begin
        lv[i] = 6'($urandom);
        if ($urandom_range(0, 7) == 0) lim[i] = 6'($urandom);
        else if ($urandom_range(0, 3) == 0) lim[i] = 6'(MX[i]);
      end
      cyc();
      for (int i = 0; i < 3; i++) begin
        total++;
        if (cnt_of(i) !== m_cnt[i] || cy[i] !== m_cy[i] || bw[i] !== m_bw[i] ||
            amx[i] !== (m_cnt[i] == emax(i)) || amn[i] !== (m_cnt[i] == MN[i]) || (cy[i] && bw[i])) begin
          bad++;
          $display("FAIL random[%0d] cyc=%0d got cnt=%0d cy=%b bw=%b max=%b min=%b exp cnt=%0d cy=%b bw=%b max=%b min=%b",
                   i, n, cnt_of(i), cy[i], bw[i], amx[i], amn[i], m_cnt[i], m_cy[i], m_bw[i],
                   (m_cnt[i] == emax(i)), (m_cnt[i] == MN[i]));
        end
      end
    end
    en = 1'b1; up = 1'b0; dn = 1'b0; ld = 1'b0;
    default_limits();
  endtask

  task automatic test_async_reset();
    ld = 1'b1; lv[0] = 6'd59; lv[1] = 6'd5; lv[2] = 6'd16;
    cyc();
    ld = 1'b0; up = 1'b1;
    cyc();
    up = 1'b0;
    total++; if (cy[0] !== 1'b1 || c0 !== 6'd0 || c2 !== 5'd17) begin
      bad++; $display("FAIL arst_setup got cy=%b c0=%0d c2=%0d exp cy=1 c0=0 c2=17", cy[0], c0, c2);
    end
    #2;
    rst = 1'b1;
    #1;
    total++; if (c2 !== 5'd1 || cy[0] !== 1'b0 || c1 !== 4'd1 || c0 !== 6'd0) begin
      bad++; $display("FAIL arst_immediate got c0=%0d cy=%b c1=%0d c2=%0d exp 0 0 1 1", c0, cy[0], c1, c2);
    end
    #1;
    rst = 1'b0;
    cyc();
    total++; if (c2 !== 5'd1 || cy[0] !== 1'b0) begin bad++; $display("FAIL arst_release got c2=%0d cy=%b exp c2=1 cy=0", c2, cy[0]); end
  endtask

  initial begin
    default_limits();
    for (int i = 0; i < 3; i++) lv[i] = 6'd0;
    test_reset();
    test_wrap();
    test_down();
    test_saturate();
    test_limit();
    test_load_clip();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
